// File: rtl/tri_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tri_dispatch_pkg
// Brief   : Shared types and default widths for the triangle dispatcher.
// Revision: 1.0
// ============================================================================
package tri_dispatch_pkg;

    localparam int c_def_num_pu = 4;
    localparam int c_def_addr_w = 13;
    localparam int c_def_data_w = 128;
    localparam int c_def_cnt_w  = 12;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_HI    = 3'd1,
        RD_LO    = 3'd2,
        WAIT_Q   = 3'd3,
        DISPATCH = 3'd4
    } state_t;

    // Owner of the RAM data returning on the next cycle.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2
    } tag_t;

endpackage
`default_nettype wire

// File: rtl/tri_dispatch_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin arbiter; scans cyclically from ptr.
// Revision: 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NUM_PU = 4,
    parameter int IDX_W  = $clog2(NUM_PU)
) (
    input  logic [NUM_PU-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_PU-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              any
);

    function automatic logic [IDX_W-1:0] wrap_idx(input int v);
        return IDX_W'(v % NUM_PU);
    endfunction

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int i = 0; i < NUM_PU; i++) begin
            if (!any && req[wrap_idx(int'(ptr) + i)]) begin
                any                              = 1'b1;
                grant_idx                        = wrap_idx(int'(ptr) + i);
                grant[wrap_idx(int'(ptr) + i)]   = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tri_dispatch.sv
`default_nettype none
// ============================================================================
// Module  : tri_dispatch
// Brief   : Fetches 2-word triangles from vertex RAM and deals them to PUs.
// Revision: 1.0
// ============================================================================
module tri_dispatch
    import tri_dispatch_pkg::*;
#(
    parameter int NUM_PU = c_def_num_pu,
    parameter int ADDR_W = c_def_addr_w,
    parameter int DATA_W = c_def_data_w,
    parameter int CNT_W  = c_def_cnt_w
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [ADDR_W-1:0]     i_base_addr,
    input  logic [CNT_W-1:0]      i_tri_count,
    output logic                  o_busy,
    output logic                  o_frame_done,
    input  logic                  i_pcie_dmard_read,
    input  logic [ADDR_W-1:0]     i_pcie_dmard_addr,
    output logic [DATA_W-1:0]     o_pcie_dmard_data,
    output logic                  o_pcie_dmard_valid,
    output logic                  o_ram_rden,
    output logic [ADDR_W-1:0]     o_ram_rdaddress,
    input  logic [DATA_W-1:0]     i_ram_q,
    input  logic [NUM_PU-1:0]     i_pu_ready,
    output logic [NUM_PU-1:0]     o_pu_valid,
    output logic [2*DATA_W-1:0]   o_pu_data
);

    localparam int IDX_W = $clog2(NUM_PU);

    state_t                r_state;
    state_t                w_next;
    tag_t                  r_tag;
    tag_t                  w_tag;
    logic [ADDR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]      r_remaining;
    logic [IDX_W-1:0]      r_rr_ptr;
    logic [2*DATA_W-1:0]   r_tri;
    logic                  r_frame_done;
    logic                  r_pcie_valid;
    logic                  w_rden;
    logic [ADDR_W-1:0]     w_addr;
    logic [NUM_PU-1:0]     w_grant;
    logic [IDX_W-1:0]      w_grant_idx;
    logic                  w_any;
    logic                  w_fire;

    rr_arbiter #(
        .NUM_PU (NUM_PU),
        .IDX_W  (IDX_W)
    ) u_arb (
        .req       (i_pu_ready),
        .ptr       (r_rr_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .any       (w_any)
    );

    assign w_fire = (r_state == DISPATCH) && w_any;

    // PCIe owns the port whenever it asks; fetch issues only otherwise.
    always_comb begin
        w_next = r_state;
        w_tag  = NONE;
        w_rden = 1'b0;
        w_addr = '0;
        if (i_pcie_dmard_read) begin
            w_rden = 1'b1;
            w_addr = i_pcie_dmard_addr;
        end
        case (r_state)
            IDLE: begin
                if (i_start && (i_tri_count != '0)) begin
                    w_next = RD_HI;
                end
            end
            RD_HI: begin
                if (!i_pcie_dmard_read) begin
                    w_rden = 1'b1;
                    w_addr = r_rd_ptr;
                    w_tag  = HI;
                    w_next = RD_LO;
                end
            end
            RD_LO: begin
                if (!i_pcie_dmard_read) begin
                    w_rden = 1'b1;
                    w_addr = r_rd_ptr + ADDR_W'(1);
                    w_tag  = LO;
                    w_next = WAIT_Q;
                end
            end
            WAIT_Q: begin
                w_next = DISPATCH;
            end
            DISPATCH: begin
                if (w_any) begin
                    w_next = (r_remaining == CNT_W'(1)) ? IDLE : RD_HI;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_tag        <= NONE;
            r_rd_ptr     <= '0;
            r_remaining  <= '0;
            r_rr_ptr     <= '0;
            r_tri        <= '0;
            r_frame_done <= 1'b0;
            r_pcie_valid <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_tag        <= w_tag;
            r_pcie_valid <= i_pcie_dmard_read;
            r_frame_done <= 1'b0;

            if ((r_state == IDLE) && i_start) begin
                if (i_tri_count != '0) begin
                    r_rd_ptr    <= i_base_addr;
                    r_remaining <= i_tri_count;
                end else begin
                    r_frame_done <= 1'b1;
                end
            end

            if (r_tag == HI) begin
                r_tri[2*DATA_W-1:DATA_W] <= i_ram_q;
            end
            if (r_tag == LO) begin
                r_tri[DATA_W-1:0] <= i_ram_q;
            end

            if (w_fire) begin
                r_rr_ptr    <= (w_grant_idx == IDX_W'(NUM_PU - 1)) ? '0 : w_grant_idx + IDX_W'(1);
                r_rd_ptr    <= r_rd_ptr + ADDR_W'(2);
                r_remaining <= r_remaining - CNT_W'(1);
                if (r_remaining == CNT_W'(1)) begin
                    r_frame_done <= 1'b1;
                end
            end
        end
    end

    assign o_busy             = (r_state != IDLE);
    assign o_frame_done       = r_frame_done;
    assign o_pcie_dmard_data  = i_ram_q;
    assign o_pcie_dmard_valid = r_pcie_valid;
    assign o_ram_rden         = w_rden;
    assign o_ram_rdaddress    = w_addr;
    assign o_pu_valid         = w_fire ? w_grant : '0;
    assign o_pu_data          = r_tri;

endmodule
`default_nettype wire

// File: tb/tb_tri_dispatch.sv
`default_nettype none
// ============================================================================
// Module  : tb_tri_dispatch
// Brief   : Scoreboard bench for tri_dispatch with a RAM model and PU model.
// Revision: 1.0
// ============================================================================
module tb_tri_dispatch;

    localparam int NUM_PU = 4;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 128;
    localparam int CNT_W  = 12;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  i_start;
    logic [ADDR_W-1:0]     i_base_addr;
    logic [CNT_W-1:0]      i_tri_count;
    logic                  o_busy;
    logic                  o_frame_done;
    logic                  i_pcie_dmard_read;
    logic [ADDR_W-1:0]     i_pcie_dmard_addr;
    logic [DATA_W-1:0]     o_pcie_dmard_data;
    logic                  o_pcie_dmard_valid;
    logic                  o_ram_rden;
    logic [ADDR_W-1:0]     o_ram_rdaddress;
    logic [DATA_W-1:0]     ram_q;
    logic [NUM_PU-1:0]     i_pu_ready;
    logic [NUM_PU-1:0]     o_pu_valid;
    logic [2*DATA_W-1:0]   o_pu_data;

    logic [DATA_W-1:0]     mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0]     exp_addr[$];
    logic [2*DATA_W-1:0]   exp_tri[$];
    logic [DATA_W-1:0]     exp_pcie[$];
    int                    grant_log[$];

    int n_vec    = 0;
    int n_err    = 0;
    int done_cnt = 0;
    int mdl_rr   = 0;
    bit rand_on  = 1'b0;
    int m_exp_u, m_act_u, m_u;

    always #5 clk = ~clk;

    tri_dispatch #(
        .NUM_PU (NUM_PU), .ADDR_W (ADDR_W), .DATA_W (DATA_W), .CNT_W (CNT_W)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .i_start            (i_start),
        .i_base_addr        (i_base_addr),
        .i_tri_count        (i_tri_count),
        .o_busy             (o_busy),
        .o_frame_done       (o_frame_done),
        .i_pcie_dmard_read  (i_pcie_dmard_read),
        .i_pcie_dmard_addr  (i_pcie_dmard_addr),
        .o_pcie_dmard_data  (o_pcie_dmard_data),
        .o_pcie_dmard_valid (o_pcie_dmard_valid),
        .o_ram_rden         (o_ram_rden),
        .o_ram_rdaddress    (o_ram_rdaddress),
        .i_ram_q            (ram_q),
        .i_pu_ready         (i_pu_ready),
        .o_pu_valid         (o_pu_valid),
        .o_pu_data          (o_pu_data)
    );

    // Synchronous-read RAM: data appears one cycle after rden.
    always @(posedge clk) begin
        if (o_ram_rden) ram_q <= mem[o_ram_rdaddress];
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: got nothing, expected an event", nm);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (o_frame_done) done_cnt++;
        if (i_pcie_dmard_read) begin
            chk("pcie_rden", o_ram_rden, 1);
            chk("pcie_addr", o_ram_rdaddress, i_pcie_dmard_addr);
        end else if (o_ram_rden) begin
            if (exp_addr.size() == 0) fail("unexpected_fetch_read");
            else chk("fetch_addr", o_ram_rdaddress, exp_addr.pop_front());
        end
        if (o_pcie_dmard_valid) begin
            if (exp_pcie.size() == 0) fail("unexpected_pcie_valid");
            else chk("pcie_data", o_pcie_dmard_data, exp_pcie.pop_front());
        end
        if (o_pu_valid != '0) begin
            m_exp_u = -1;
            for (int k = 0; k < NUM_PU; k++) begin
                m_u = (mdl_rr + k) % NUM_PU;
                if (m_exp_u < 0 && i_pu_ready[m_u]) m_exp_u = m_u;
            end
            m_act_u = -1;
            for (int k = 0; k < NUM_PU; k++) if (o_pu_valid[k]) m_act_u = k;
            chk("pu_onehot", $onehot(o_pu_valid), 1);
            chk("pu_grant", m_act_u, m_exp_u);
            grant_log.push_back(m_act_u);
            mdl_rr = ((m_exp_u >= 0 ? m_exp_u : m_act_u) + 1) % NUM_PU;
            if (exp_tri.size() == 0) fail("unexpected_triangle");
            else chk("pu_data", o_pu_data, exp_tri.pop_front());
        end
    end

    // Background random ready / PCIe traffic
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_on) begin
                i_pu_ready = NUM_PU'($urandom);
                if ($urandom_range(3) == 0) begin
                    i_pcie_dmard_read = 1'b1;
                    i_pcie_dmard_addr = ADDR_W'($urandom);
                    exp_pcie.push_back(mem[i_pcie_dmard_addr]);
                end else begin
                    i_pcie_dmard_read = 1'b0;
                end
            end
        end
    end

    task automatic do_start(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] cnt);
        logic [ADDR_W-1:0] a0;
        @(posedge clk); #1;
        i_start     = 1'b1;
        i_base_addr = base;
        i_tri_count = cnt;
        for (int k = 0; k < int'(cnt); k++) begin
            a0 = base + ADDR_W'(2 * k);
            exp_addr.push_back(a0);
            exp_addr.push_back(a0 + ADDR_W'(1));
            exp_tri.push_back({mem[a0], mem[a0 + ADDR_W'(1)]});
        end
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int t;
        t = 0;
        while (done_cnt <= d0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt <= d0) fail("frame_done_timeout");
        repeat (2) @(negedge clk);
        chk("done_once", done_cnt, d0 + 1);
        chk("tri_left", exp_tri.size(), 0);
        chk("addr_left", exp_addr.size(), 0);
        chk("busy_after", o_busy, 0);
    endtask

    task automatic run_frame(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] cnt);
        int d0;
        d0 = done_cnt;
        do_start(base, cnt);
        wait_done(d0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_tri.delete();
        exp_addr.delete();
        mdl_rr = 0;
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_busy"}, o_busy, 0);
        chk({nm, "_done"}, o_frame_done, 0);
        chk({nm, "_rden"}, o_ram_rden, 0);
        chk({nm, "_rdaddr"}, o_ram_rdaddress, 0);
        chk({nm, "_valid"}, o_pu_valid, 0);
        chk({nm, "_data"}, o_pu_data, 0);
        chk({nm, "_pcie_valid"}, o_pcie_dmard_valid, 0);
    endtask

    initial begin
        int d0;
        int t;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        rst = 1'b1;
        i_start = 1'b0;
        i_base_addr = '0;
        i_tri_count = '0;
        i_pcie_dmard_read = 1'b0;
        i_pcie_dmard_addr = '0;
        i_pu_ready = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_idle_outputs("reset");

        // Single triangle with exact latency
        i_pu_ready = 4'b0001;
        d0 = done_cnt;
        do_start(13'h010, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("single_valid", o_pu_valid, 4'b0001);
        chk("single_data", o_pu_data, {mem[13'h010], mem[13'h011]});
        @(negedge clk);
        chk("single_done_pulse", o_frame_done, 1);
        wait_done(d0);

        // Round-robin from a fresh pointer
        do_reset();
        i_pu_ready = 4'b1111;
        grant_log.delete();
        run_frame(13'h040, 5);
        chk("rr_count", grant_log.size(), 5);
        if (grant_log.size() == 5) begin
            chk("rr_g0", grant_log[0], 0);
            chk("rr_g1", grant_log[1], 1);
            chk("rr_g2", grant_log[2], 2);
            chk("rr_g3", grant_log[3], 3);
            chk("rr_g4", grant_log[4], 0);
        end

        // Readiness skip
        grant_log.delete();
        i_pu_ready = 4'b0000;
        d0 = done_cnt;
        do_start(13'h300, 3);
        repeat (6) @(posedge clk);
        chk("skip_no_grant_yet", grant_log.size(), 0);
        #1 i_pu_ready = 4'b0100;
        t = 0;
        while (grant_log.size() < 1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (grant_log.size() < 1) fail("skip_first_grant_timeout");
        @(posedge clk); #1;
        i_pu_ready = 4'b0010;
        wait_done(d0);
        chk("skip_count", grant_log.size(), 3);
        if (grant_log.size() == 3) begin
            chk("skip_g0", grant_log[0], 2);
            chk("skip_g1", grant_log[1], 1);
            chk("skip_g2", grant_log[2], 1);
        end

        // PCIe steals the port in the RD_LO cycle
        i_pu_ready = 4'b1000;
        d0 = done_cnt;
        do_start(13'h0A0, 1);
        @(posedge clk); #1;
        i_pcie_dmard_read = 1'b1;
        i_pcie_dmard_addr = 13'h1F00;
        exp_pcie.push_back(mem[13'h1F00]);
        @(posedge clk); #1;
        i_pcie_dmard_read = 1'b0;
        wait_done(d0);
        chk("pcie_drained", exp_pcie.size(), 0);

        // Address wrap and zero-length frame
        i_pu_ready = 4'b1111;
        run_frame(13'h1FFE, 2);
        d0 = done_cnt;
        do_start(13'h0123, 0);
        @(negedge clk);
        chk("zero_done", o_frame_done, 1);
        chk("zero_busy", o_busy, 0);
        wait_done(d0);

        // Reset while stuck in DISPATCH
        i_pu_ready = 4'b0000;
        do_start(13'h100, 3);
        repeat (6) @(posedge clk);
        d0 = done_cnt;
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_idle_outputs("midreset");
        repeat (3) @(negedge clk);
        chk("midreset_no_done", done_cnt, d0);
        exp_tri.delete();
        exp_addr.delete();
        mdl_rr = 0;
        grant_log.delete();
        i_pu_ready = 4'b1111;
        run_frame(13'h200, 2);
        chk("midreset_count", grant_log.size(), 2);
        if (grant_log.size() == 2) chk("midreset_first_pu0", grant_log[0], 0);

        // Randomised frames with random readiness and PCIe contention
        rand_on = 1'b1;
        for (int f = 0; f < 8; f++) begin
            run_frame(ADDR_W'($urandom), CNT_W'($urandom_range(1, 6)));
        end
        rand_on = 1'b0;
        @(posedge clk); #1;
        i_pcie_dmard_read = 1'b0;
        repeat (3) @(negedge clk);
        chk("rand_pcie_drained", exp_pcie.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
